// File: rtl/planet_integrator.sv
// N-body timestep engine: walks every (i, j) planet pair through an external force
// calculator, accumulates forces, then applies semi-implicit Euler on a wrapping 128x64 field.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | committed state stable; accepts loads and start
// S_ACCUM  | one j per cycle, summing the force on planet i
// S_UPDATE | new velocity/position of planet i written to shadow copies
// S_COMMIT | shadows copied over committed state; done on the next cycle
module planet_integrator #(
    parameter int NUM_PLANETS = 4,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [6:0]       load_x,
    input  logic [5:0]       load_y,
    input  logic [15:0]      load_vx,
    input  logic [15:0]      load_vy,
    output logic [6:0]       x_pos_object,
    output logic [5:0]       y_pos_object,
    output logic [6:0]       x_pos_other,
    output logic [5:0]       y_pos_other,
    input  logic [13:0]      x_force,
    input  logic [13:0]      y_force,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [6:0]       rd_x,
    output logic [5:0]       rd_y
);
    localparam int ACC_W = 14 + IDX_W;
    localparam int SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PLANETS - 1);
    localparam logic signed [SUM_W-1:0] VMAX = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] VMIN = SUM_W'(-32768);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE, S_COMMIT} state_t;

    state_t r_state, w_next;

    logic [14:0] r_pos_x [NUM_PLANETS];
    logic [13:0] r_pos_y [NUM_PLANETS];
    logic [15:0] r_vel_x [NUM_PLANETS];
    logic [15:0] r_vel_y [NUM_PLANETS];
    logic [14:0] r_nxt_pos_x [NUM_PLANETS];
    logic [13:0] r_nxt_pos_y [NUM_PLANETS];
    logic [15:0] r_nxt_vel_x [NUM_PLANETS];
    logic [15:0] r_nxt_vel_y [NUM_PLANETS];

    logic [IDX_W-1:0]        r_i, r_j;
    logic signed [ACC_W-1:0] r_acc_x, r_acc_y;
    logic                    r_busy, r_done;

    logic                    w_skip;
    logic signed [ACC_W-1:0] w_fx_ext, w_fy_ext;
    logic signed [SUM_W-1:0] w_sum_x, w_sum_y;
    logic [15:0]             w_vnx, w_vny;
    logic [14:0]             w_pnx;
    logic [13:0]             w_pny;

    function automatic logic [15:0] sat16(input logic signed [SUM_W-1:0] v);
        if (v > VMAX)      return 16'h7FFF;
        else if (v < VMIN) return 16'h8000;
        else               return v[15:0];
    endfunction

    assign busy         = r_busy;
    assign done         = r_done;
    assign x_pos_object = r_pos_x[r_i][14:8];
    assign y_pos_object = r_pos_y[r_i][13:8];
    assign x_pos_other  = r_pos_x[r_j][14:8];
    assign y_pos_other  = r_pos_y[r_j][13:8];
    assign rd_x         = r_pos_x[rd_idx][14:8];
    assign rd_y         = r_pos_y[rd_idx][13:8];

    // Self-pairs and coincident planets contribute nothing (force is singular there).
    assign w_skip   = (r_i == r_j) ||
                      ((x_pos_object == x_pos_other) && (y_pos_object == y_pos_other));
    assign w_fx_ext = ACC_W'($signed(x_force));
    assign w_fy_ext = ACC_W'($signed(y_force));
    assign w_sum_x  = SUM_W'($signed(r_vel_x[r_i])) + SUM_W'(r_acc_x);
    assign w_sum_y  = SUM_W'($signed(r_vel_y[r_i])) + SUM_W'(r_acc_y);
    assign w_vnx    = sat16(w_sum_x);
    assign w_vny    = sat16(w_sum_y);
    // Truncated add gives toroidal wrap because position and velocity share 8 fraction bits.
    assign w_pnx    = r_pos_x[r_i] + w_vnx[14:0];
    assign w_pny    = r_pos_y[r_i] + w_vny[13:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start && !load_en) w_next = S_ACCUM;
            S_ACCUM:  if (r_j == LAST) w_next = S_UPDATE;
            S_UPDATE: w_next = (r_i == LAST) ? S_COMMIT : S_ACCUM;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_PLANETS; k++) begin
                r_pos_x[k]     <= '0;
                r_pos_y[k]     <= '0;
                r_vel_x[k]     <= '0;
                r_vel_y[k]     <= '0;
                r_nxt_pos_x[k] <= '0;
                r_nxt_pos_y[k] <= '0;
                r_nxt_vel_x[k] <= '0;
                r_nxt_vel_y[k] <= '0;
            end
            r_i     <= '0;
            r_j     <= '0;
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_COMMIT);
            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        if (int'(load_idx) < NUM_PLANETS) begin
                            r_pos_x[load_idx] <= {load_x, 8'h00};
                            r_pos_y[load_idx] <= {load_y, 8'h00};
                            r_vel_x[load_idx] <= load_vx;
                            r_vel_y[load_idx] <= load_vy;
                        end
                    end else if (start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_acc_x <= '0;
                        r_acc_y <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (!w_skip) begin
                        r_acc_x <= r_acc_x + w_fx_ext;
                        r_acc_y <= r_acc_y + w_fy_ext;
                    end
                    r_j <= (r_j == LAST) ? '0 : r_j + 1'b1;
                end
                S_UPDATE: begin
                    r_nxt_vel_x[r_i] <= w_vnx;
                    r_nxt_vel_y[r_i] <= w_vny;
                    r_nxt_pos_x[r_i] <= w_pnx;
                    r_nxt_pos_y[r_i] <= w_pny;
                    r_acc_x          <= '0;
                    r_acc_y          <= '0;
                    r_j              <= '0;
                    if (r_i != LAST) r_i <= r_i + 1'b1;
                end
                S_COMMIT: begin
                    for (int k = 0; k < NUM_PLANETS; k++) begin
                        r_pos_x[k] <= r_nxt_pos_x[k];
                        r_pos_y[k] <= r_nxt_pos_y[k];
                        r_vel_x[k] <= r_nxt_vel_x[k];
                        r_vel_y[k] <= r_nxt_vel_y[k];
                    end
                    r_busy <= 1'b0;
                    r_i    <= '0;
                    r_j    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_planet_integrator.sv
// Bench for planet_integrator: a whole-step arithmetic model of the simulation plus a
// pair-schedule tracker, checked every cycle, with literal expectations for directed cases.
module tb_planet_integrator;
    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int STEP_CNT = N * (N + 1) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic          load_en = 1'b0;
    logic [IW-1:0] load_idx = '0;
    logic [6:0]    load_x = '0;
    logic [5:0]    load_y = '0;
    logic [15:0]   load_vx = '0;
    logic [15:0]   load_vy = '0;
    logic [6:0]    x_pos_object, x_pos_other;
    logic [5:0]    y_pos_object, y_pos_other;
    logic [13:0]   x_force, y_force;
    logic [IW-1:0] rd_idx = '0;
    logic [6:0]    rd_x;
    logic [5:0]    rd_y;

    int checks = 0;
    int errors = 0;
    int fmode = 0;
    int fseed = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    planet_integrator #(.NUM_PLANETS(N), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .load_en(load_en), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
        .load_vx(load_vx), .load_vy(load_vy),
        .x_pos_object(x_pos_object), .y_pos_object(y_pos_object),
        .x_pos_other(x_pos_other), .y_pos_other(y_pos_other),
        .x_force(x_force), .y_force(y_force),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y)
    );

    // Stand-in force calculator: 0 = none, 1 = constant +1.0 in x, 2/3 = position hash (small/large).
    function automatic int force_of(input int axis, input int mode, input int seed,
                                    input int xo, input int yo, input int xt, input int yt);
        int h;
        if (mode == 0) return 0;
        if (mode == 1) return (axis == 0) ? 256 : 0;
        h = (axis == 0) ? (xo * 37 + yo * 11 + xt * 53 + yt * 17 + seed)
                        : (xo * 13 + yo * 41 + xt * 7 + yt * 29 + seed * 3);
        if (mode == 2) begin
            h = h & 32'h3FF;
            if (h >= 512) h = h - 1024;
        end else begin
            h = h & 32'h3FFF;
            if (h >= 8192) h = h - 16384;
        end
        return h;
    endfunction

    assign x_force = 14'(force_of(0, fmode, fseed, int'(x_pos_object), int'(y_pos_object),
                                  int'(x_pos_other), int'(y_pos_other)));
    assign y_force = 14'(force_of(1, fmode, fseed, int'(x_pos_object), int'(y_pos_object),
                                  int'(x_pos_other), int'(y_pos_other)));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: positions/velocities as plain integers in 1/256 units.
    int m_px [N];
    int m_py [N];
    int m_vx [N];
    int m_vy [N];
    int m_cnt = 0;
    bit m_done = 1'b0;

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_step();
        int nx [N];
        int ny [N];
        int nvx [N];
        int nvy [N];
        int ax, ay;
        for (int i = 0; i < N; i++) begin
            ax = 0;
            ay = 0;
            for (int j = 0; j < N; j++) begin
                if (j != i && !((m_px[i] >> 8) == (m_px[j] >> 8) && (m_py[i] >> 8) == (m_py[j] >> 8))) begin
                    ax += force_of(0, fmode, fseed, m_px[i] >> 8, m_py[i] >> 8, m_px[j] >> 8, m_py[j] >> 8);
                    ay += force_of(1, fmode, fseed, m_px[i] >> 8, m_py[i] >> 8, m_px[j] >> 8, m_py[j] >> 8);
                end
            end
            nvx[i] = clamp16(m_vx[i] + ax);
            nvy[i] = clamp16(m_vy[i] + ay);
            nx[i]  = (m_px[i] + nvx[i]) & 32'h7FFF;
            ny[i]  = (m_py[i] + nvy[i]) & 32'h3FFF;
        end
        for (int i = 0; i < N; i++) begin
            m_px[i] = nx[i];
            m_py[i] = ny[i];
            m_vx[i] = nvx[i];
            m_vy[i] = nvy[i];
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                m_px[k] = 0; m_py[k] = 0; m_vx[k] = 0; m_vy[k] = 0;
            end
            m_cnt  = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (load_en) begin
                    m_px[load_idx] = int'(load_x) * 256;
                    m_py[load_idx] = int'(load_y) * 256;
                    m_vx[load_idx] = int'($signed(load_vx));
                    m_vy[load_idx] = int'($signed(load_vy));
                end else if (start) begin
                    m_cnt = 1;
                end
            end else if (m_cnt == STEP_CNT) begin
                model_step();
                m_cnt  = 0;
                m_done = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        int k, ei, ej;
        if (done) done_pulses++;
        chk("busy", int'(busy), int'(m_cnt != 0));
        chk("done", int'(done), int'(m_done));
        chk("rd_x", int'(rd_x), m_px[rd_idx] >> 8);
        chk("rd_y", int'(rd_y), m_py[rd_idx] >> 8);
        ei = -1;
        ej = -1;
        if (m_cnt == 0) begin
            ei = 0;
            ej = 0;
        end else if (m_cnt <= N * (N + 1)) begin
            k = m_cnt - 1;
            if (k % (N + 1) < N) begin
                ei = k / (N + 1);
                ej = k % (N + 1);
            end
        end
        if (ei >= 0) begin
            chk("x_pos_object", int'(x_pos_object), m_px[ei] >> 8);
            chk("y_pos_object", int'(y_pos_object), m_py[ei] >> 8);
            chk("x_pos_other",  int'(x_pos_other),  m_px[ej] >> 8);
            chk("y_pos_other",  int'(y_pos_other),  m_py[ej] >> 8);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        rd_idx = IW'($urandom_range(0, N - 1));
    endtask

    task automatic load(input int idx, input int x, input int y, input int vx, input int vy);
        load_en  = 1'b1;
        load_idx = IW'(idx);
        load_x   = 7'(x);
        load_y   = 6'(y);
        load_vx  = 16'(vx);
        load_vy  = 16'(vy);
        tick();
        load_en  = 1'b0;
    endtask

    task automatic peek(input int idx, output int ox, output int oy);
        rd_idx = IW'(idx);
        #1;
        ox = int'(rd_x);
        oy = int'(rd_y);
    endtask

    // Runs one timestep; poke injects a load and a start while busy, which must be ignored.
    task automatic run_step(input bit poke);
        int busy_n, done_cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_n = 0;
        done_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_n++;
            if (poke && c == 5) begin
                load_en = 1'b1; load_idx = '0; load_x = 7'd99; load_y = 6'd33;
                load_vx = 16'h1234; load_vy = 16'h4321;
            end
            if (poke && c == 9) start = 1'b1;
            tick();
            load_en = 1'b0;
            start = 1'b0;
            if (done) begin
                done_cyc = c + 1;
                break;
            end
        end
        chk("busy_cycles", busy_n, 21);
        chk("done_cycle", done_cyc, 22);
        tick();
    endtask

    initial begin
        int ox, oy, pulses0, nrst;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        for (int r = 0; r < N; r++) begin
            peek(r, ox, oy);
            chk("reset_rd_x", ox, 0);
            chk("reset_rd_y", oy, 0);
        end
        chk("reset_x_obj", int'(x_pos_object), 0);
        chk("reset_y_oth", int'(y_pos_other), 0);

        // Free motion
        fmode = 0;
        load(0, 10, 20, 16'h0100, 0);
        run_step(1'b0);
        peek(0, ox, oy);
        chk("free_x", ox, 11);
        chk("free_y", oy, 20);

        // Wrap in x and y
        load(1, 127, 10, 16'h0100, 0);
        load(2, 50, 0, 0, 16'hFF00);
        run_step(1'b0);
        peek(1, ox, oy);
        chk("wrap_x", ox, 0);
        peek(2, ox, oy);
        chk("wrap_y", oy, 63);
        peek(0, ox, oy);
        chk("free_x2", ox, 12);

        // Accumulation over three partners
        fmode = 1;
        load(0, 5, 5, 0, 0);
        load(1, 20, 10, 0, 0);
        load(2, 40, 30, 0, 0);
        load(3, 100, 50, 0, 0);
        run_step(1'b0);
        peek(0, ox, oy); chk("acc_x0", ox, 8);   chk("acc_y0", oy, 5);
        peek(1, ox, oy); chk("acc_x1", ox, 23);
        peek(2, ox, oy); chk("acc_x2", ox, 43);
        peek(3, ox, oy); chk("acc_x3", ox, 103);

        // Overlapping pair skips each other
        load(0, 30, 30, 0, 0);
        load(1, 30, 30, 0, 0);
        load(2, 60, 10, 0, 0);
        load(3, 90, 40, 0, 0);
        run_step(1'b0);
        peek(0, ox, oy); chk("ovl_x0", ox, 32);
        peek(1, ox, oy); chk("ovl_x1", ox, 32);
        peek(2, ox, oy); chk("ovl_x2", ox, 63);
        peek(3, ox, oy); chk("ovl_x3", ox, 93);

        // Saturation with start/load attempts while busy
        load(0, 0, 5, 16'h7F00, 0);
        load(1, 20, 10, 0, 0);
        load(2, 40, 30, 0, 0);
        load(3, 100, 50, 0, 0);
        pulses0 = done_pulses;
        run_step(1'b1);
        repeat (4) tick();
        chk("done_once", done_pulses - pulses0, 1);
        peek(0, ox, oy); chk("sat_x0", ox, 127); chk("sat_y0", oy, 5);
        peek(1, ox, oy); chk("sat_x1", ox, 23);

        // Randomized steps, one of them aborted by reset
        nrst = $urandom_range(0, 5);
        for (int it = 0; it < 6; it++) begin
            fmode = $urandom_range(2, 3);
            fseed = $urandom_range(0, 1000);
            for (int p = 0; p < N; p++)
                load(p, $urandom_range(0, 127), $urandom_range(0, 63),
                     $urandom_range(0, 65535), $urandom_range(0, 65535));
            if (it % 2 == 0) load(1, int'(m_px[0] >> 8), int'(m_py[0] >> 8), 16'h0040, 16'hFFC0);
            if (it == nrst) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                repeat ($urandom_range(3, 18)) tick();
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                tick();
                for (int r = 0; r < N; r++) begin
                    peek(r, ox, oy);
                    chk("abort_rd_x", ox, 0);
                    chk("abort_rd_y", oy, 0);
                end
            end else begin
                run_step(1'b0);
                run_step(1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/planet_integrator.md
Name: planet_integrator

Overview:
- Holds position and velocity state for NUM_PLANETS planets and advances the simulation by one timestep per start pulse.
- Drives one object/other position pair per cycle to an external combinational force calculator. That calculator takes 7-bit x and 6-bit y positions and returns 14-bit signed 5.8 x/y forces.
- Accumulates the returned forces, then integrates velocity and position with semi-implicit Euler on a wrapping 128x64 field.
- Committed positions go to the display/renderer through a read port.

Parameters:
- NUM_PLANETS, 4, number of simulated planets (2..16).
- IDX_W, 2, index width, equal to clog2(NUM_PLANETS).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run one timestep.
- busy  out  1  high from accepted start until commit.
- done  out  1  one-cycle pulse after commit.
- load_en  in  1  write initial state of one planet.
- load_idx  in  IDX_W  planet written.
- load_x  in  7  integer x position.
- load_y  in  6  integer y position.
- load_vx  in  16  velocity x, signed 8.8.
- load_vy  in  16  velocity y, signed 8.8.
- x_pos_object  out  7  to force calculator, integer x of planet i.
- y_pos_object  out  6  to force calculator, integer y of planet i.
- x_pos_other  out  7  to force calculator, integer x of planet j.
- y_pos_other  out  6  to force calculator, integer y of planet j.
- x_force  in  14  signed 5.8 force on i from j, same-cycle combinational return.
- y_force  in  14  signed 5.8 force on i from j, same-cycle combinational return.
- rd_idx  in  IDX_W  display read index.
- rd_x  out  7  committed integer x of rd_idx, combinational.
- rd_y  out  6  committed integer y of rd_idx, combinational.

Behaviour:
- Internal state per planet:
  - pos_x is 15 bits (7.8 unsigned); pos_y is 14 bits (6.8 unsigned).
  - vel_x and vel_y are 16 bits (8.8 signed).
  - Next-state shadow copies of position and velocity are written during UPDATE and copied over the committed state in COMMIT, so every force in a step uses start-of-step positions.
- Reset: all positions, velocities, shadows and accumulators are 0; busy=0, done=0, state IDLE, i=j=0. Position outputs are therefore 0.
- Position outputs:
  - x_pos_object/y_pos_object are the integer bits of committed planet i.
  - x_pos_other/y_pos_other are the integer bits of committed planet j.
  - Both are driven from registers in every state.
- IDLE:
  - load_en writes pos = {load_x, 8'h00}, {load_y, 8'h00} and the loaded velocities into committed state.
  - start with load_en low: go to ACCUM with i=0, j=0, accumulators cleared, busy=1.
  - start and load_en in the same cycle: the load is performed and start is ignored.
- ACCUM: one cycle per j, from 0 to NUM_PLANETS-1.
  - Add the sign-extended x_force and y_force into 14+IDX_W-bit signed accumulators.
  - Skip the add when j==i.
  - Also skip the add when both integer positions are equal (overlap ignored).
  - After j=NUM_PLANETS-1, go to UPDATE.
- UPDATE (1 cycle):
  - vnew = sat16(vel + sext(acc)); force LSB equals velocity LSB; saturate to 0x7FFF/0x8000.
  - posnew = (pos + sext(vnew)), taken mod 2^15 for x and mod 2^14 for y, so positions wrap toroidally.
  - Write shadows; clear accumulators.
  - If i<NUM_PLANETS-1: i++, j=0, back to ACCUM. Otherwise go to COMMIT.
- COMMIT (1 cycle): shadows are copied to committed state, busy falls, i=j=0, go to IDLE. done=1 for exactly the following cycle.
- Latency: start is sampled at cycle 0 and done is high at cycle NUM_PLANETS*(NUM_PLANETS+1)+2, which is 22 for the default.
- While busy, start and load_en are ignored.
- rd_x/rd_y always show committed state, never shadows.
- Reset asserted mid-step aborts immediately to the reset state; no partial commit.

Test Plan:
- Reset: after reset_n release, busy=0, done=0, rd_x=rd_y=0 for every rd_idx, all position outputs 0.
- Free motion: load planet 0 at (10,20) with vx=0x0100, vy=0; forces tied to 0; pulse start. Required: busy for 21 cycles, done at cycle 22, then rd_x=11, rd_y=20.
- Wrap: planet at x=127 with vx=0x0100 gives x=0; planet at y=0 with vy=0xFF00 gives y=63.
- Accumulation: 4 planets at distinct positions, bench returns x_force=0x0100 for every pair. Required: each vx=0x0300 and each x increases by 3. Also check pair order: i=0 shows j=0..3, then i=1.
- Overlap/self skip: planets 0 and 1 at identical position, the rest distinct, force 0x0100 returned always. Required: planets 0 and 1 end with vx=0x0200; planets 2 and 3 end with vx=0x0300.
- Saturation and busy guard: vx=0x7F00 with 3x force 0x0100 gives vx=0x7FFF. A start or load_en issued during busy changes nothing and done pulses once only.
